// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, constants and S-box
package aes_pkg;

    localparam int KEY_WORDS  = 4;
    localparam int NUM_ROUNDS = 11;
    localparam int EXP_WORDS  = KEY_WORDS * NUM_ROUNDS;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        KS_IDLE  = 2'd0,
        KS_RUN   = 2'd1,
        KS_DRAIN = 2'd2,
        KS_DONE  = 2'd3
    } ks_state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] s_box(input logic [7:0] b);
        return SBOX_FLAT[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Word n of a 128-bit key, word 0 in the top 32 bits.
    function automatic word_t key_word(input round_key_t k, input logic [1:0] n);
        return k[(3 - int'(n)) * 32 +: 32];
    endfunction

endpackage

// File: rtl/key_expander.sv
// rtl/key_expander.sv - single-word AES-128 key expander with registered output
module key_expander
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_i,
    input  word_t      key_i_1_i,
    input  word_t      key_N_i_i,
    input  logic [7:0] rc_i,
    output logic [7:0] rc_o,
    output word_t      key_o
);

    word_t      rot_w;
    word_t      sub_w;
    word_t      next_w;
    logic [7:0] rc_next;

    // Next expanded word; round constant advances after every use and restarts on the key words.
    always_comb begin
        rot_w   = {key_i_1_i[23:0], key_i_1_i[31:24]};
        sub_w   = {s_box(rot_w[31:24]), s_box(rot_w[23:16]), s_box(rot_w[15:8]), s_box(rot_w[7:0])};
        next_w  = key_N_i_i ^ key_i_1_i;
        rc_next = rc_i;
        if (i_i < 8'd4) begin
            next_w  = key_i_1_i;
            rc_next = 8'h01;
        end else if (i_i[1:0] == 2'b00) begin
            next_w  = key_N_i_i ^ sub_w ^ {rc_i, 24'h0};
            rc_next = xtime(rc_i);
        end
    end

    // Word and round-constant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_o <= '0;
            rc_o  <= '0;
        end else begin
            key_o <= next_w;
            rc_o  <= rc_next;
        end
    end

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - key schedule controller paired with its word expander
module key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    input  logic [3:0]   rk_sel_i,
    output logic [127:0] rk_o
);

    logic [7:0] kx_i;
    word_t      kx_key_i_1;
    word_t      kx_key_N_i;
    logic [7:0] kx_rc_in;
    logic [7:0] kx_rc_out;
    word_t      kx_key;

    key_schedule_ctrl u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .key_i        (key_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rk_sel_i     (rk_sel_i),
        .rk_o         (rk_o),
        .kx_i_o       (kx_i),
        .kx_key_i_1_o (kx_key_i_1),
        .kx_key_N_i_o (kx_key_N_i),
        .kx_rc_o      (kx_rc_in),
        .kx_rc_i      (kx_rc_out),
        .kx_key_i     (kx_key)
    );

    key_expander u_exp (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_i       (kx_i),
        .key_i_1_i (kx_key_i_1),
        .key_N_i_i (kx_key_N_i),
        .rc_i      (kx_rc_in),
        .rc_o      (kx_rc_out),
        .key_o     (kx_key)
    );

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - sequences the word expander and serves round keys
module key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    input  logic [3:0]   rk_sel_i,
    output logic [127:0] rk_o,
    output logic [7:0]   kx_i_o,
    output logic [31:0]  kx_key_i_1_o,
    output logic [31:0]  kx_key_N_i_o,
    output logic [7:0]   kx_rc_o,
    input  logic [7:0]   kx_rc_i,
    input  logic [31:0]  kx_key_i
);

    ks_state_e  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       busy_d, done_d;
    logic       load_key, issue;
    round_key_t key_q;
    logic       cap_valid_q;
    logic [5:0] cap_idx_q;
    logic [5:0] rk_base;
    word_t      wbuf_q [EXP_WORDS];

    // Next state; a start while busy is ignored because RUN/DRAIN never look at start_i.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_o;
        done_d   = done_o;
        load_key = 1'b0;
        issue    = 1'b0;
        case (state_q)
            KS_IDLE, KS_DONE: begin
                if (start_i) begin
                    state_d  = KS_RUN;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    load_key = 1'b1;
                end
            end
            KS_RUN: begin
                issue = 1'b1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(EXP_WORDS - 1)) begin
                    state_d = KS_DRAIN;
                end
            end
            KS_DRAIN: begin
                state_d = KS_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        endcase
    end

    // Expander operands: cipher key words first, then previous word forwarded plus word i-4.
    always_comb begin
        kx_i_o       = '0;
        kx_key_i_1_o = '0;
        kx_key_N_i_o = '0;
        if (issue) begin
            kx_i_o = {2'b00, cnt_q};
            if (cnt_q < 6'd4) begin
                kx_key_i_1_o = key_word(key_q, cnt_q[1:0]);
            end else begin
                kx_key_i_1_o = kx_key_i;
                kx_key_N_i_o = wbuf_q[cnt_q - 6'd4];
            end
        end
    end

    assign kx_rc_o = kx_rc_i;
    assign rk_base = {rk_sel_i, 2'b00};

    // Control registers and key latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= KS_IDLE;
            cnt_q       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            key_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            cap_valid_q <= issue;
            cap_idx_q   <= cnt_q;
            if (load_key) begin
                key_q <= key_i;
            end
        end
    end

    // Word buffer: the expander output lands one cycle after its index was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < EXP_WORDS; i++) begin
                wbuf_q[i] <= '0;
            end
        end else if (cap_valid_q) begin
            wbuf_q[cap_idx_q] <= kx_key_i;
        end
    end

    // Round-key read port; held at zero unless the buffer is complete and staying so.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_o <= '0;
        end else if (state_q == KS_DONE && state_d == KS_DONE && rk_sel_i < 4'(NUM_ROUNDS)) begin
            rk_o <= {wbuf_q[rk_base], wbuf_q[rk_base + 6'd1],
                     wbuf_q[rk_base + 6'd2], wbuf_q[rk_base + 6'd3]};
        end else begin
            rk_o <= '0;
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl
`timescale 1ns/1ps
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic         busy_o, done_o;
    logic [3:0]   rk_sel_i;
    logic [127:0] rk_o;
    logic [7:0]   kx_i_o, kx_rc_o, kx_rc_i;
    logic [31:0]  kx_key_i_1_o, kx_key_N_i_o, kx_key_i;

    key_schedule_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
        .busy_o(busy_o), .done_o(done_o), .rk_sel_i(rk_sel_i), .rk_o(rk_o),
        .kx_i_o(kx_i_o), .kx_key_i_1_o(kx_key_i_1_o), .kx_key_N_i_o(kx_key_N_i_o),
        .kx_rc_o(kx_rc_o), .kx_rc_i(kx_rc_i), .kx_key_i(kx_key_i)
    );

    key_expander u_exp (
        .clk(clk), .rst_n(rst_n), .i_i(kx_i_o), .key_i_1_i(kx_key_i_1_o),
        .key_N_i_i(kx_key_N_i_o), .rc_i(kx_rc_o), .rc_o(kx_rc_i), .key_o(kx_key_i)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   sel;
        logic [127:0] exp;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sbox_ref [256];
    logic [7:0] rc_exp   [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    // Textbook AES-128 key expansion over the whole schedule.
    function automatic logic [127:0] ref_rk(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]], sbox_ref[t[31:24]]}
                    ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    task automatic read_rk(input logic [3:0] sel, output logic [127:0] val);
        rk_sel_i = sel;
        step();
        val = rk_o;
    endtask

    // Start an expansion and follow it to done, checking sequencing on the way.
    task automatic run_key(input logic [127:0] k, input bit extra_starts);
        int lat = 0;
        bit seq_ok = 1'b1, rc_ok = 1'b1, busy_ok = 1'b1;
        key_i    = k;
        start_i  = 1'b1;
        rk_sel_i = 4'd0;
        step();
        start_i = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n <= 44 && kx_i_o !== 8'(n - 1)) seq_ok = 1'b0;
            if (n >= 5 && n <= 44 && (n - 1) % 4 == 0 && kx_rc_o !== rc_exp[(n - 1) / 4 - 1]) rc_ok = 1'b0;
            if (n <= 45 && (busy_o !== 1'b1 || done_o !== 1'b0 || rk_o !== 128'h0)) busy_ok = 1'b0;
            if (done_o === 1'b1) begin
                lat = n;
                break;
            end
            if (extra_starts && (n == 10 || n == 30)) begin
                start_i = 1'b1;
                key_i   = ~k;
            end else begin
                start_i = 1'b0;
            end
            step();
        end
        start_i = 1'b0;
        key_i   = k;
        check("done_latency", 128'(lat), 128'd46);
        check("busy_after_done", 128'(busy_o), 128'd0);
        check("kx_index_sequence", 128'(seq_ok), 128'd1);
        check("kx_rc_sequence", 128'(rc_ok), 128'd1);
        check("busy_window_outputs", 128'(busy_ok), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         vecs [8];
        logic [127:0] cur;
        logic [127:0] got;
        logic [127:0] rkey;
        logic [7:0]   inv;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        vecs[0] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
        vecs[1] = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{FIPS_KEY, 4'd11, 128'h0};
        vecs[4] = '{ZERO_KEY, 4'd1,  128'h62636363626363636263636362636363};
        vecs[5] = '{ZERO_KEY, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[6] = '{ZERO_KEY, 4'd12, 128'h0};
        vecs[7] = '{ZERO_KEY, 4'd15, 128'h0};

        rst_n    = 1'b0;
        start_i  = 1'b0;
        key_i    = '0;
        rk_sel_i = 4'd0;
        repeat (3) step();
        check("reset_busy", 128'(busy_o), 128'd0);
        check("reset_done", 128'(done_o), 128'd0);
        check("reset_rk", rk_o, 128'h0);
        check("reset_kx_i", 128'(kx_i_o), 128'd0);
        check("reset_kx_key_i_1", 128'(kx_key_i_1_o), 128'd0);
        check("reset_kx_key_N_i", 128'(kx_key_N_i_o), 128'd0);
        check("reset_kx_rc", 128'(kx_rc_o), 128'd0);
        rst_n = 1'b1;
        step();
        read_rk(4'd1, got);
        check("idle_rk_zero", got, 128'h0);

        cur = ~FIPS_KEY;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].key !== cur) begin
                run_key(vecs[i].key, 1'b0);
                cur = vecs[i].key;
            end
            read_rk(vecs[i].sel, got);
            check($sformatf("vector_%0d_sel_%0d", i, vecs[i].sel), got, vecs[i].exp);
        end

        run_key(FIPS_KEY, 1'b1);
        read_rk(4'd1, got);
        check("extra_starts_rk1", got, ref_rk(FIPS_KEY, 1));
        read_rk(4'd10, got);
        check("extra_starts_rk10", got, ref_rk(FIPS_KEY, 10));

        run_key(ZERO_KEY, 1'b0);
        key_i   = FIPS_KEY;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (19) step();
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 128'(busy_o), 128'd0);
        check("midrun_reset_done", 128'(done_o), 128'd0);
        check("midrun_reset_rk", rk_o, 128'h0);
        repeat (2) step();
        check("midrun_reset_held_busy", 128'(busy_o), 128'd0);
        rst_n = 1'b1;
        step();
        read_rk(4'd1, got);
        check("midrun_no_partial_done", 128'(done_o), 128'd0);
        check("midrun_no_partial_rk", got, 128'h0);
        run_key(FIPS_KEY, 1'b0);
        read_rk(4'd10, got);
        check("after_reset_rk10", got, ref_rk(FIPS_KEY, 10));

        run_key(ZERO_KEY, 1'b0);
        read_rk(4'd1, got);
        check("b2b_zero_rk1", got, 128'h62636363626363636263636362636363);
        read_rk(4'd10, got);
        check("b2b_zero_rk10", got, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_rk(4'd12, got);
        check("b2b_sel12_zero", got, 128'h0);

        for (int t = 0; t < 4; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_key(rkey, 1'b0);
            for (int r = 0; r < 11; r++) begin
                read_rk(4'(r), got);
                check($sformatf("random_%0d_rk%0d", t, r), got, ref_rk(rkey, r));
            end
            read_rk(4'(11 + $urandom_range(0, 4)), got);
            check($sformatf("random_%0d_sel_oob", t), got, 128'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
